// File: rtl/exp3_tester.sv
// Stimulus/response checker for the four-input function exp3: sweeps {A,B,C,D}
// over 0..15, compares the returned F against the golden function and records errors.
module exp3_tester #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       F,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] fail_vec
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_V = 4'(SETTLE);

    state_t     state_r, state_nxt;
    logic [3:0] vec_r, vec_nxt;
    logic [3:0] wait_r, wait_nxt;
    logic [3:0] stim_r, stim_nxt;
    logic       busy_r, busy_nxt;
    logic       done_r, done_nxt;
    logic       pass_r, pass_nxt;
    logic [4:0] err_r, err_nxt;
    logic       fv_r, fv_nxt;
    logic [3:0] fvec_r, fvec_nxt;
    logic       accept_s;
    logic       mism_s;

    function automatic logic golden(input logic [3:0] v);
        return (v[3] & ~v[2]) | (~v[3] & v[2] & (v[1] | v[0]));
    endfunction

    // Start is only honoured when no sweep is running.
    assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign mism_s   = (F != golden(vec_r));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nxt = APPLY;
                end else begin
                    state_nxt = state_r;
                end
            end
            APPLY: begin
                if (SETTLE_V == 4'd0) begin
                    state_nxt = CHECK;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_r <= 4'd1) begin
                    state_nxt = CHECK;
                end else begin
                    state_nxt = WAIT;
                end
            end
            CHECK: begin
                if (vec_r == 4'd15) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = APPLY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        vec_nxt  = vec_r;
        wait_nxt = wait_r;
        stim_nxt = stim_r;
        busy_nxt = busy_r;
        done_nxt = done_r;
        pass_nxt = pass_r;
        err_nxt  = err_r;
        fv_nxt   = fv_r;
        fvec_nxt = fvec_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    vec_nxt  = 4'd0;
                    stim_nxt = 4'd0;
                    busy_nxt = 1'b1;
                    done_nxt = 1'b0;
                    pass_nxt = 1'b0;
                    err_nxt  = 5'd0;
                    fv_nxt   = 1'b0;
                    fvec_nxt = 4'd0;
                end else begin
                    busy_nxt = 1'b0;
                end
            end
            APPLY: begin
                wait_nxt = SETTLE_V;
            end
            WAIT: begin
                wait_nxt = wait_r - 4'd1;
            end
            CHECK: begin
                if (mism_s) begin
                    err_nxt = err_r + 5'd1;
                    if (!fv_r) begin
                        fv_nxt   = 1'b1;
                        fvec_nxt = vec_r;
                    end else begin
                        fv_nxt   = fv_r;
                    end
                end else begin
                    err_nxt = err_r;
                end
                // Vector 15 ends the sweep; the index is never advanced past it.
                if (vec_r == 4'd15) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                    pass_nxt = (err_nxt == 5'd0);
                end else begin
                    vec_nxt  = vec_r + 4'd1;
                    stim_nxt = vec_r + 4'd1;
                end
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_r  <= 4'd0;
            wait_r <= 4'd0;
            stim_r <= 4'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= 5'd0;
            fv_r   <= 1'b0;
            fvec_r <= 4'd0;
        end else begin
            vec_r  <= vec_nxt;
            wait_r <= wait_nxt;
            stim_r <= stim_nxt;
            busy_r <= busy_nxt;
            done_r <= done_nxt;
            pass_r <= pass_nxt;
            err_r  <= err_nxt;
            fv_r   <= fv_nxt;
            fvec_r <= fvec_nxt;
        end
    end

    assign {A, B, C, D} = stim_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pass         = pass_r;
    assign err_count    = err_r;
    assign fail_valid   = fv_r;
    assign fail_vec     = fvec_r;

endmodule

// File: tb/tb_exp3_tester.sv
// Directed bench for exp3_tester: table of faulty-DUT models on a SETTLE=1 instance,
// plus hand-written restart/reset sequences on a SETTLE=0 instance.
module tb_exp3_tester;

    logic clk = 1'b0;
    logic rst;
    logic start1, start0;
    logic F1, F0;
    logic A1, B1, C1, D1, busy1, done1, pass1, fv1;
    logic A0, B0, C0, D0, busy0, done0, pass0, fv0;
    logic [4:0] err1, err0;
    logic [3:0] fvec1, fvec0;
    logic [3:0] v1, v0;
    int mode;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exp3_tester #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .F(F1),
        .A(A1), .B(B1), .C(C1), .D(D1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_valid(fv1), .fail_vec(fvec1)
    );

    exp3_tester #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .F(F0),
        .A(A0), .B(B0), .C(C0), .D(D0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_valid(fv0), .fail_vec(fvec0)
    );

    function automatic logic gold(input logic [3:0] v);
        return (v >= 4'd5) && (v <= 4'd11);
    endfunction

    assign v1 = {A1, B1, C1, D1};
    assign v0 = {A0, B0, C0, D0};
    assign F0 = gold(v0);

    // Circuit-under-test models: 0 correct, 1 tied 0, 2 tied 1, 3 wrong at 7, 4 wrong at 15.
    always_comb begin
        case (mode)
            1:       F1 = 1'b0;
            2:       F1 = 1'b1;
            3:       F1 = (v1 == 4'd7) ? 1'b0 : gold(v1);
            4:       F1 = (v1 == 4'd15) ? 1'b1 : gold(v1);
            default: F1 = gold(v1);
        endcase
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called on a negedge; returns busy-cycle count and timeout flag.
    task automatic sweep1(output int bc, output bit to);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("start_flags1", int'({done1, pass1, fv1, busy1}), 1);
        chk("start_err1", int'(err1), 0);
        bc = 0;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done1) begin
                to = 1'b0;
                break;
            end
            if (busy1) bc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int mode;
        int err;
        int fv;
        int fvec;
        int pass;
    } vec_t;

    vec_t tbl[6];
    int   bc;
    bit   to;
    bit   found;

    initial begin
        tbl[0] = '{0, 0, 0, 0,  1};
        tbl[1] = '{1, 7, 1, 5,  0};
        tbl[2] = '{2, 9, 1, 0,  0};
        tbl[3] = '{3, 1, 1, 7,  0};
        tbl[4] = '{4, 1, 1, 15, 0};
        tbl[5] = '{0, 0, 0, 0,  1};

        mode   = 0;
        rst    = 1'b1;
        start1 = 1'b0;
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out1", int'({v1, busy1, done1, pass1, err1, fv1, fvec1}), 0);
        chk("reset_out0", int'({v0, busy0, done0, pass0, err0, fv0, fvec0}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            mode = tbl[t].mode;
            sweep1(bc, to);
            chk("sweep_timeout", int'(to), 0);
            chk("busy_cycles", bc, 48);
            chk("done", int'(done1), 1);
            chk("busy_after", int'(busy1), 0);
            chk("pass", int'(pass1), tbl[t].pass);
            chk("err_count", int'(err1), tbl[t].err);
            chk("fail_valid", int'(fv1), tbl[t].fv);
            chk("fail_vec", int'(fvec1), tbl[t].fvec);
            chk("last_vec_held", int'(v1), 15);
            repeat (3) @(negedge clk);
            chk("done_held", int'({done1, pass1}), tbl[t].pass + 2);
        end

        // Second start pulse mid-sweep must be ignored.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        bc = 0;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done0) begin
                to = 1'b0;
                break;
            end
            if (busy0) bc++;
            start0 = (i == 10);
            @(negedge clk);
        end
        start0 = 1'b0;
        chk("s0_timeout", int'(to), 0);
        chk("s0_busy_cycles", bc, 32);
        chk("s0_pass", int'(pass0), 1);

        // Reset while vector 6 is applied clears everything immediately.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (v0 == 4'd6) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_vec6", int'(found), 1);
        chk("busy_at_vec6", int'(busy0), 1);
        rst = 1'b1;
        #1;
        chk("abort_out0", int'({v0, busy0, done0, pass0, err0, fv0, fvec0}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_stays_idle", int'({busy0, done0}), 0);

        // Restart after abort begins at vector 0.
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("restart_vec0", int'({v0, busy0}), 1);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("restart_timeout", int'(to), 0);
        chk("restart_pass", int'({pass0, err0}), 32);

        // start together with rst: rst wins.
        rst    = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_start_busy", int'({busy1, done1}), 0);
        @(negedge clk);
        rst    = 1'b0;
        start1 = 1'b0;
        @(negedge clk);
        chk("rst_start_idle", int'({busy1, done1, v1}), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
